tm1638_key_reader: RTL and testbench
====================================

Name: tm1638_key_reader

Overview:
- Reads the TM1638 key-scan matrix.
- Issues the read-key command 0x42 over the 3-wire TM1638 bus (STB, CLK, bidirectional DIO), then shifts in 4 key-data bytes.
- Presents the 8 front-panel key states with a one-cycle valid strobe.
- It is the read-direction counterpart to the segment/LED write path. It shares the bus pins with the display driver via a top-level mux selected by o_Busy.

Parameters:
- CLK_DIV_CYCLES, 4: i_Clk cycles per SCLK half-period (H); legal range ≥1.
- WAIT_CYCLES, 8: i_Clk cycles between the command's last rising edge and the first read clock (W); legal range ≥0, and 0 skips WAIT. Must cover TM1638 Twait ≥1 µs.

Ports:
- i_Clk  in  1  system clock; all logic on posedge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Start  in  1  request one key scan; sampled only in IDLE.
- i_Dio  in  1  DIO pad input.
- o_Stb  out  1  TM1638 STB, active low.
- o_SClk  out  1  TM1638 CLK; idles high.
- o_Dio_Out  out  1  DIO drive value.
- o_Dio_Oe  out  1  DIO output enable; 1 = drive.
- o_Busy  out  1  transaction in progress; grants bus ownership.
- o_Raw  out  32  raw key bytes; byte k occupies bits [8k+7:8k].
- o_Keys  out  8  decoded keys, 1 = pressed.
- o_Valid  out  1  one-cycle strobe; o_Raw/o_Keys updated this cycle.

Behaviour:
- Clocking and reset:
  - One clock (i_Clk); reset is synchronous and active-high (i_Rst).
  - All outputs are registered.
  - Reset values: o_Stb=1, o_SClk=1, o_Dio_Out=1, o_Dio_Oe=0, o_Busy=0, o_Raw=0, o_Keys=0, o_Valid=0; state IDLE; counters 0.
- States: IDLE → STB_SETUP → CMD → WAIT → READ → STB_HOLD → DONE → IDLE.
- Acceptance:
  - i_Start=1 in IDLE is accepted on that edge, called cycle 0.
  - i_Start in any other state is ignored; requests are not queued.
- STB_SETUP (H cycles, cycles 1..H): o_Stb=0, o_Busy=1, o_SClk=1, o_Dio_Oe=1, o_Dio_Out=1.
- CMD (16H cycles):
  - 8 bits of 0x42, LSB first.
  - Each bit is H cycles with SCLK low, then H cycles with SCLK high.
  - o_Dio_Out changes only on the cycle SCLK goes low; the value is stable across the rising edge.
- WAIT (W cycles): o_SClk=1, o_Dio_Oe=0.
- READ (64H cycles):
  - 32 bits, same SCLK shape as CMD; o_Dio_Oe=0.
  - i_Dio is sampled on the last i_Clk cycle of each low phase, immediately before SCLK rises.
  - Shift order is LSB first, byte 0 first: bit n of the stream maps to o_Raw[n].
  - o_Raw is not updated until DONE.
- STB_HOLD (H cycles): o_SClk=1, o_Stb=0.
- DONE (cycle 82H+W+1, one cycle):
  - o_Stb=1, o_Busy=0, o_Valid=1.
  - o_Raw and o_Keys load the shifted data.
  - Next state is IDLE. i_Start is first re-sampled in the following cycle, so at least one IDLE cycle separates transactions.
- Decode, for k=0..3: o_Keys[k] = byte k bit 0; o_Keys[k+4] = byte k bit 4. All other raw bits appear only in o_Raw.
- o_Raw and o_Keys hold their values between o_Valid strobes.
- Reset mid-transaction: on the next edge, all reset values are restored. o_Stb is released, no o_Valid is produced, and o_Raw/o_Keys are cleared.
- Counters wrap only by state transition. A half-period counter sized to hold H−1 and a bit counter of 0..31 are sufficient.

Test Plan:
- Reset → all outputs at reset values. i_Start held low for 50 cycles → o_Stb, o_SClk and o_Busy stay 1, 1, 0.
- H=2, W=4, single i_Start pulse; monitor DIO on the first 8 o_SClk rising edges with Oe=1 → bits 0,1,0,0,0,0,1,0 (0x42). o_Stb falls at cycle 1. Oe=0 from cycle 35.
- H=2, W=4; chip model drives bytes 0x01, 0x10, 0x00, 0x11, each bit changed only on SCLK falling edges → o_Valid=1 exactly at cycle 169 for one cycle. o_Raw=0x11001001, o_Keys=0xA9, o_Stb=1 on that cycle.
- Model drives 0xFF for all bytes → o_Raw=0xFFFFFFFF, o_Keys=0xFF. A following scan of all-zero bytes → 0x00000000 / 0x00. Values hold between strobes.
- i_Start held high continuously → back-to-back transactions, exactly one IDLE cycle between DONE and the next o_Stb fall. Extra pulses during a transaction start nothing.
- i_Rst asserted at READ bit 10 → next cycle o_Stb=1, o_Busy=0, o_Raw=0, o_Keys=0, no o_Valid. A subsequent i_Start completes normally at +169 cycles.

Source files
------------

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader
//   Reads the TM1638 key-scan matrix over the 3-wire bus. It sends the
//   read-key command 0x42 LSB first, releases DIO, waits the chip's Twait
//   time, and then clocks in 32 data bits (4 bytes, LSB first, byte 0
//   first). The transaction ends with one o_Valid strobe, and on that cycle
//   o_Raw/o_Keys are loaded.
//   o_Busy grants bus ownership to this block in the top-level pin mux.
//
// Ports
//   i_Clk      system clock, posedge
//   i_Rst      synchronous active-high reset
//   i_Start    request one key scan (sampled only in IDLE)
//   i_Dio      DIO pad input
//   o_Stb      TM1638 STB, active low
//   o_SClk     TM1638 CLK, idles high
//   o_Dio_Out  DIO drive value
//   o_Dio_Oe   DIO output enable, 1 = drive
//   o_Busy     transaction in progress
//   o_Raw      raw key bytes, byte k at [8k+7:8k]
//   o_Keys     decoded front-panel keys, 1 = pressed
//   o_Valid    one-cycle strobe, o_Raw/o_Keys updated this cycle
//
// state       | meaning
// S_IDLE      | bus released, waiting for i_Start
// S_STB_SETUP | STB low, SCLK high, DIO driven 1 for H cycles
// S_CMD       | shift out 0x42, LSB first, 2H cycles per bit
// S_WAIT      | DIO released, SCLK high for W cycles (Twait)
// S_READ      | shift in 32 key bits, LSB first
// S_STB_HOLD  | SCLK high, STB still low for H cycles
// S_DONE      | STB released, publish data, pulse o_Valid

module tm1638_key_reader #(
   parameter int CLK_DIV_CYCLES = 4,
   parameter int WAIT_CYCLES    = 8
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Start,
   input  logic        i_Dio,
   output logic        o_Stb,
   output logic        o_SClk,
   output logic        o_Dio_Out,
   output logic        o_Dio_Oe,
   output logic        o_Busy,
   output logic [31:0] o_Raw,
   output logic [7:0]  o_Keys,
   output logic        o_Valid
);

   localparam int H       = CLK_DIV_CYCLES;
   localparam int W       = WAIT_CYCLES;
   localparam int CNT_MAX = (H > W) ? H : W;
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
   localparam logic [CW-1:0] W_LAST   = CW'((W > 0) ? (W - 1) : 0);
   localparam logic [7:0]    CMD_READ = 8'h42;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STB_SETUP,
      S_CMD,
      S_WAIT,
      S_READ,
      S_STB_HOLD,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [4:0]    bit_cnt, bit_nxt;
   logic          phase_hi, phase_nxt;
   logic [31:0]   shift, shift_nxt;

   logic          stb_nxt, sclk_nxt, dout_nxt, oe_nxt, busy_nxt, valid_nxt;
   logic [31:0]   raw_nxt;
   logic [7:0]    keys_nxt;

   logic          cnt_last;
   assign cnt_last = (cnt == H_LAST);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      phase_nxt = phase_hi;
      shift_nxt = shift;
      stb_nxt   = 1'b1;
      sclk_nxt  = 1'b1;
      dout_nxt  = 1'b1;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      valid_nxt = 1'b0;
      raw_nxt   = o_Raw;
      keys_nxt  = o_Keys;

      case (state)
         S_IDLE: begin
            if (i_Start) begin
               state_nxt = S_STB_SETUP;
               cnt_nxt   = '0;
            end
         end

         S_STB_SETUP: begin
            stb_nxt  = 1'b0;
            busy_nxt = 1'b1;
            oe_nxt   = 1'b1;
            if (cnt_last) begin
               state_nxt = S_CMD;
               cnt_nxt   = '0;
               bit_nxt   = '0;
               phase_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_CMD: begin
            stb_nxt  = 1'b0;
            busy_nxt = 1'b1;
            oe_nxt   = 1'b1;
            sclk_nxt = phase_hi;
            // Bit index only advances at the start of a low phase, so DIO
            // is stable across the rising edge.
            dout_nxt = CMD_READ[bit_cnt[2:0]];
            if (cnt_last) begin
               cnt_nxt = '0;
               if (!phase_hi) begin
                  phase_nxt = 1'b1;
               end else begin
                  phase_nxt = 1'b0;
                  if (bit_cnt == 5'd7) begin
                     bit_nxt   = '0;
                     state_nxt = (W == 0) ? S_READ : S_WAIT;
                  end else begin
                     bit_nxt = bit_cnt + 5'd1;
                  end
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_WAIT: begin
            stb_nxt  = 1'b0;
            busy_nxt = 1'b1;
            if (cnt == W_LAST) begin
               state_nxt = S_READ;
               cnt_nxt   = '0;
               bit_nxt   = '0;
               phase_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_READ: begin
            stb_nxt  = 1'b0;
            busy_nxt = 1'b1;
            sclk_nxt = phase_hi;
            // The pins lag the state by one register stage. The edge that
            // drives SCLK high therefore sees DIO as it was during the last
            // low cycle.
            if (phase_hi && (cnt == '0)) begin
               shift_nxt[bit_cnt] = i_Dio;
            end
            if (cnt_last) begin
               cnt_nxt = '0;
               if (!phase_hi) begin
                  phase_nxt = 1'b1;
               end else begin
                  phase_nxt = 1'b0;
                  if (bit_cnt == 5'd31) begin
                     bit_nxt   = '0;
                     state_nxt = S_STB_HOLD;
                  end else begin
                     bit_nxt = bit_cnt + 5'd1;
                  end
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_STB_HOLD: begin
            stb_nxt  = 1'b0;
            busy_nxt = 1'b1;
            if (cnt_last) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_DONE: begin
            valid_nxt = 1'b1;
            raw_nxt   = shift;
            for (int k = 0; k < 4; k++) begin
               keys_nxt[k]     = shift[8*k];
               keys_nxt[k + 4] = shift[8*k + 4];
            end
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         phase_hi  <= 1'b0;
         shift     <= '0;
         o_Stb     <= 1'b1;
         o_SClk    <= 1'b1;
         o_Dio_Out <= 1'b1;
         o_Dio_Oe  <= 1'b0;
         o_Busy    <= 1'b0;
         o_Raw     <= '0;
         o_Keys    <= '0;
         o_Valid   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_nxt;
         phase_hi  <= phase_nxt;
         shift     <= shift_nxt;
         o_Stb     <= stb_nxt;
         o_SClk    <= sclk_nxt;
         o_Dio_Out <= dout_nxt;
         o_Dio_Oe  <= oe_nxt;
         o_Busy    <= busy_nxt;
         o_Raw     <= raw_nxt;
         o_Keys    <= keys_nxt;
         o_Valid   <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader
//   Self-checking bench for tm1638_key_reader with H=2, W=4. A small
//   TM1638 pin model collects the command bits on SCLK rising edges and
//   drives key bits on SCLK falling edges while DIO is released. Cycle k
//   counts posedges after the edge that accepts i_Start (cycle 0).

module tb_tm1638_key_reader;

   localparam int H = 2;
   localparam int W = 4;
   localparam int T_VALID = 82*H + W + 1;
   localparam int T_OE_OFF = 17*H + 1;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic        i_Start = 1'b0;
   logic        i_Dio = 1'b1;
   logic        o_Stb, o_SClk, o_Dio_Out, o_Dio_Oe, o_Busy, o_Valid;
   logic [31:0] o_Raw;
   logic [7:0]  o_Keys;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] chip_data = 32'h0;
   int          chip_idx = 0;
   logic        sclk_q = 1'b1;
   logic        stb_q = 1'b1;
   logic        cmd_bits[$];

   tm1638_key_reader #(
      .CLK_DIV_CYCLES(H),
      .WAIT_CYCLES(W)
   ) dut (
      .i_Clk(i_Clk),
      .i_Rst(i_Rst),
      .i_Start(i_Start),
      .i_Dio(i_Dio),
      .o_Stb(o_Stb),
      .o_SClk(o_SClk),
      .o_Dio_Out(o_Dio_Out),
      .o_Dio_Oe(o_Dio_Oe),
      .o_Busy(o_Busy),
      .o_Raw(o_Raw),
      .o_Keys(o_Keys),
      .o_Valid(o_Valid)
   );

   always #5 i_Clk = ~i_Clk;

   // TM1638 pin model: the key stream bit n is chip_data[n], presented after
   // the n-th SCLK falling edge of the read phase.
   always @(posedge i_Clk) begin
      #2;
      if (stb_q && !o_Stb) begin
         chip_idx = 0;
         cmd_bits.delete();
      end
      if (!sclk_q && o_SClk && o_Dio_Oe)
         cmd_bits.push_back(o_Dio_Out);
      if (sclk_q && !o_SClk && !o_Dio_Oe && !o_Stb && chip_idx < 32) begin
         i_Dio = chip_data[chip_idx];
         chip_idx = chip_idx + 1;
      end
      sclk_q = o_SClk;
      stb_q = o_Stb;
   end

   function automatic logic [7:0] model_keys(input logic [31:0] raw);
      logic [7:0] keys;
      logic [7:0] byte_v;
      keys = '0;
      for (int k = 0; k < 4; k++) begin
         byte_v = 8'((raw >> (8*k)) & 32'hFF);
         keys[k] = byte_v[0];
         keys[k + 4] = byte_v[4];
      end
      return keys;
   endfunction

   task automatic run_scan(input logic [31:0] data, output int c_stb, output int c_oe,
                           output int c_valid, output int n_valid,
                           output logic [31:0] raw_at, output logic [7:0] keys_at,
                           output logic stb_at);
      chip_data = data;
      c_stb = -1; c_oe = -1; c_valid = -1; n_valid = 0;
      raw_at = 'x; keys_at = 'x; stb_at = 1'bx;
      @(negedge i_Clk);
      i_Start = 1'b1;
      @(posedge i_Clk);
      #1 i_Start = 1'b0;
      for (int k = 1; k <= 250; k++) begin
         @(posedge i_Clk);
         #1;
         if (c_stb < 0 && o_Stb == 1'b0) c_stb = k;
         if (c_stb >= 0 && c_oe < 0 && o_Dio_Oe == 1'b0) c_oe = k;
         if (o_Valid) begin
            n_valid++;
            if (c_valid < 0) begin
               c_valid = k;
               raw_at = o_Raw;
               keys_at = o_Keys;
               stb_at = o_Stb;
            end
         end
      end
   endtask

   task automatic test_reset;
      logic bad;
      i_Rst = 1'b1;
      repeat (3) @(posedge i_Clk);
      #1;
      total_cnt += 8;
      if (o_Stb !== 1'b1) $display("FAIL reset_stb got %b want 1", o_Stb); else pass_cnt++;
      if (o_SClk !== 1'b1) $display("FAIL reset_sclk got %b want 1", o_SClk); else pass_cnt++;
      if (o_Dio_Out !== 1'b1) $display("FAIL reset_dout got %b want 1", o_Dio_Out); else pass_cnt++;
      if (o_Dio_Oe !== 1'b0) $display("FAIL reset_oe got %b want 0", o_Dio_Oe); else pass_cnt++;
      if (o_Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_Busy); else pass_cnt++;
      if (o_Raw !== 32'h0) $display("FAIL reset_raw got %h want 0", o_Raw); else pass_cnt++;
      if (o_Keys !== 8'h0) $display("FAIL reset_keys got %h want 0", o_Keys); else pass_cnt++;
      if (o_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_Valid); else pass_cnt++;
      @(negedge i_Clk);
      i_Rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge i_Clk);
         #1;
         if (o_Stb !== 1'b1 || o_SClk !== 1'b1 || o_Busy !== 1'b0) bad = 1'b1;
      end
      total_cnt++;
      if (bad) $display("FAIL idle_hold stb/sclk/busy=%b%b%b want 110", o_Stb, o_SClk, o_Busy);
      else pass_cnt++;
   endtask

   task automatic test_cmd_and_timing;
      int c_stb, c_oe, c_valid, n_valid;
      logic [31:0] raw_at;
      logic [7:0] keys_at, cmd_val;
      logic stb_at;
      run_scan(32'h11001001, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
      cmd_val = '0;
      for (int i = 0; i < 8 && i < cmd_bits.size(); i++) cmd_val[i] = cmd_bits[i];
      total_cnt += 9;
      if (c_stb !== 1) $display("FAIL stb_fall_cycle got %0d want 1", c_stb); else pass_cnt++;
      if (c_oe !== T_OE_OFF) $display("FAIL oe_off_cycle got %0d want %0d", c_oe, T_OE_OFF); else pass_cnt++;
      if (cmd_bits.size() !== 8) $display("FAIL cmd_bit_count got %0d want 8", cmd_bits.size()); else pass_cnt++;
      if (cmd_val !== 8'h42) $display("FAIL cmd_value got %h want 42", cmd_val); else pass_cnt++;
      if (c_valid !== T_VALID) $display("FAIL valid_cycle got %0d want %0d", c_valid, T_VALID); else pass_cnt++;
      if (n_valid !== 1) $display("FAIL valid_width got %0d want 1", n_valid); else pass_cnt++;
      if (raw_at !== 32'h11001001) $display("FAIL raw_basic got %h want 11001001", raw_at); else pass_cnt++;
      if (keys_at !== 8'hA9) $display("FAIL keys_basic got %h want a9", keys_at); else pass_cnt++;
      if (stb_at !== 1'b1) $display("FAIL stb_at_done got %b want 1", stb_at); else pass_cnt++;
   endtask

   task automatic test_extremes_and_hold;
      int c_stb, c_oe, c_valid, n_valid;
      logic [31:0] raw_at;
      logic [7:0] keys_at;
      logic stb_at;
      run_scan(32'hFFFFFFFF, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
      total_cnt += 4;
      if (raw_at !== 32'hFFFFFFFF) $display("FAIL raw_ones got %h want ffffffff", raw_at); else pass_cnt++;
      if (keys_at !== 8'hFF) $display("FAIL keys_ones got %h want ff", keys_at); else pass_cnt++;
      if (o_Raw !== 32'hFFFFFFFF) $display("FAIL raw_hold got %h want ffffffff", o_Raw); else pass_cnt++;
      if (o_Keys !== 8'hFF) $display("FAIL keys_hold got %h want ff", o_Keys); else pass_cnt++;
      run_scan(32'h00000000, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
      total_cnt += 2;
      if (raw_at !== 32'h0) $display("FAIL raw_zeros got %h want 0", raw_at); else pass_cnt++;
      if (keys_at !== 8'h00) $display("FAIL keys_zeros got %h want 0", keys_at); else pass_cnt++;
   endtask

   task automatic test_random;
      int c_stb, c_oe, c_valid, n_valid;
      logic [31:0] raw_at, data;
      logic [7:0] keys_at;
      logic stb_at;
      for (int i = 0; i < 4; i++) begin
         data = $urandom;
         run_scan(data, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
         total_cnt += 3;
         if (c_valid !== T_VALID) $display("FAIL rand_valid_cycle[%0d] got %0d want %0d", i, c_valid, T_VALID); else pass_cnt++;
         if (raw_at !== data) $display("FAIL rand_raw[%0d] got %h want %h", i, raw_at, data); else pass_cnt++;
         if (keys_at !== model_keys(data)) $display("FAIL rand_keys[%0d] got %h want %h", i, keys_at, model_keys(data)); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back;
      int valid_cyc[$];
      int fall_cyc[$];
      logic prev_stb;
      chip_data = 32'h11001001;
      prev_stb = o_Stb;
      @(negedge i_Clk);
      i_Start = 1'b1;
      @(posedge i_Clk);
      for (int k = 1; k <= 520; k++) begin
         @(posedge i_Clk);
         #1;
         if (o_Valid) valid_cyc.push_back(k);
         if (prev_stb && !o_Stb) fall_cyc.push_back(k);
         prev_stb = o_Stb;
      end
      i_Start = 1'b0;
      repeat (200) @(posedge i_Clk);
      total_cnt += 4;
      if (valid_cyc.size() < 2 || fall_cyc.size() < 2) begin
         $display("FAIL b2b_count got valid=%0d falls=%0d want >=2 each", valid_cyc.size(), fall_cyc.size());
         total_cnt -= 3;
      end else begin
         pass_cnt++;
         if (valid_cyc[0] !== T_VALID) $display("FAIL b2b_first_valid got %0d want %0d", valid_cyc[0], T_VALID); else pass_cnt++;
         if (fall_cyc[1] !== valid_cyc[0] + 2) $display("FAIL b2b_gap got %0d want %0d", fall_cyc[1], valid_cyc[0] + 2); else pass_cnt++;
         if (valid_cyc[1] !== 2*T_VALID + 1) $display("FAIL b2b_second_valid got %0d want %0d", valid_cyc[1], 2*T_VALID + 1); else pass_cnt++;
      end
   endtask

   task automatic test_extra_pulses;
      int n_valid, n_fall;
      logic prev_stb;
      n_valid = 0; n_fall = 0;
      prev_stb = o_Stb;
      @(negedge i_Clk);
      i_Start = 1'b1;
      @(posedge i_Clk);
      #1 i_Start = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge i_Clk);
         #1;
         i_Start = 1'b0;
         if (o_Valid) n_valid++;
         if (prev_stb && !o_Stb) n_fall++;
         prev_stb = o_Stb;
         if (k == 50 || k == 100 || k == T_VALID - 1) i_Start = 1'b1;
      end
      i_Start = 1'b0;
      total_cnt += 2;
      if (n_valid !== 1) $display("FAIL extra_pulse_valids got %0d want 1", n_valid); else pass_cnt++;
      if (n_fall !== 1) $display("FAIL extra_pulse_stb_falls got %0d want 1", n_fall); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int c_stb, c_oe, c_valid, n_valid, late_valid;
      logic [31:0] raw_at, data;
      logic [7:0] keys_at;
      logic stb_at;
      // Load nonzero key data first so the clear is observable.
      run_scan(32'h11001001, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
      chip_data = 32'hA5A5A5A5;
      @(negedge i_Clk);
      i_Start = 1'b1;
      @(posedge i_Clk);
      #1 i_Start = 1'b0;
      // READ begins at cycle 17H+W+1; bit 10 occupies cycles 79..82 here.
      for (int k = 1; k <= 79; k++) @(posedge i_Clk);
      #1;
      total_cnt++;
      if (o_Busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", o_Busy); else pass_cnt++;
      @(negedge i_Clk);
      i_Rst = 1'b1;
      @(posedge i_Clk);
      #1;
      total_cnt += 5;
      if (o_Stb !== 1'b1) $display("FAIL mid_rst_stb got %b want 1", o_Stb); else pass_cnt++;
      if (o_Busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", o_Busy); else pass_cnt++;
      if (o_Raw !== 32'h0) $display("FAIL mid_rst_raw got %h want 0", o_Raw); else pass_cnt++;
      if (o_Keys !== 8'h0) $display("FAIL mid_rst_keys got %h want 0", o_Keys); else pass_cnt++;
      if (o_Valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", o_Valid); else pass_cnt++;
      @(negedge i_Clk);
      i_Rst = 1'b0;
      late_valid = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge i_Clk);
         #1;
         if (o_Valid) late_valid++;
      end
      total_cnt++;
      if (late_valid !== 0) $display("FAIL mid_rst_no_valid got %0d want 0", late_valid); else pass_cnt++;
      data = $urandom;
      run_scan(data, c_stb, c_oe, c_valid, n_valid, raw_at, keys_at, stb_at);
      total_cnt += 3;
      if (c_valid !== T_VALID) $display("FAIL post_rst_valid_cycle got %0d want %0d", c_valid, T_VALID); else pass_cnt++;
      if (raw_at !== data) $display("FAIL post_rst_raw got %h want %h", raw_at, data); else pass_cnt++;
      if (keys_at !== model_keys(data)) $display("FAIL post_rst_keys got %h want %h", keys_at, model_keys(data)); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_cmd_and_timing();
      test_extremes_and_hold();
      test_random();
      test_back_to_back();
      test_extra_pulses();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
